// File: rtl/weight_stream_pkg.sv
// Shared types and default geometry for the weight-stream sink buffer.
// Row packing places lane j of beat b at element index b*PAR+j.
package weight_stream_pkg;

  localparam int WS_DIM_0 = 32;
  localparam int WS_DIM_1 = 4;
  localparam int WS_PREC  = 16;
  localparam int WS_PAR   = 4;

  localparam int BEATS_PER_ROW = WS_DIM_0 / WS_PAR;
  localparam int ROW_WIDTH     = WS_PREC * WS_DIM_0;
  localparam int ADDR_WIDTH    = $clog2(WS_DIM_1) + 1;

  typedef enum logic {LOAD = 1'b0, DONE = 1'b1} sink_state_t;

  typedef logic [ROW_WIDTH-1:0] weight_row_t;

  function automatic int lane_offset(input int beat, input int lane, input int par, input int prec);
    return (beat * par + lane) * prec;
  endfunction

endpackage

// File: rtl/weight_row_ram.sv
// Simple dual-port row RAM: one write port, one read-first read port with a
// two-stage ce-gated output pipeline. Out-of-range read addresses return zero.
module weight_row_ram #(
  parameter int WIDTH  = 512,
  parameter int DEPTH  = 4,
  parameter int AW     = 3,
  parameter int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [MEM_AW-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              ce,
  input  logic [AW-1:0]     raddr,
  output logic [WIDTH-1:0]  q
);

  localparam logic [AW-1:0] DEPTH_A = AW'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [WIDTH-1:0] stage0_r;
  logic [WIDTH-1:0] q_r;

  // Write port; contents deliberately have no reset so the array maps to block RAM
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Read pipeline; nonblocking read of mem_r gives read-first collision behaviour
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage0_r <= '0;
      q_r      <= '0;
    end else if (ce) begin
      if (raddr < DEPTH_A) begin
        stage0_r <= mem_r[raddr[MEM_AW-1:0]];
      end else begin
        stage0_r <= '0;
      end
      q_r <= stage0_r;
    end
  end

  assign q = q_r;

endmodule

// File: rtl/weight_stream_sink_buffer.sv
// Receives the lane-parallel weight stream, packs each row into a wide word
// and stores it in a row RAM that compute blocks read through a ROM-style port.
module weight_stream_sink_buffer
  import weight_stream_pkg::*;
#(
  parameter int WEIGHT_TENSOR_SIZE_DIM_0 = WS_DIM_0,
  parameter int WEIGHT_TENSOR_SIZE_DIM_1 = WS_DIM_1,
  parameter int WEIGHT_PRECISION_0       = WS_PREC,
  parameter int WEIGHT_PARALLELISM_DIM_0 = WS_PAR
) (
  input  logic                                                clk,
  input  logic                                                rst_n,
  input  logic [WEIGHT_PRECISION_0-1:0]                       data_in [WEIGHT_PARALLELISM_DIM_0],
  input  logic                                                data_in_valid,
  output logic                                                data_in_ready,
  input  logic                                                reload,
  output logic                                                load_done,
  output logic [$clog2(WEIGHT_TENSOR_SIZE_DIM_1):0]           rows_loaded,
  input  logic [$clog2(WEIGHT_TENSOR_SIZE_DIM_1):0]           address0,
  input  logic                                                ce0,
  output logic [WEIGHT_PRECISION_0*WEIGHT_TENSOR_SIZE_DIM_0-1:0] q0
);

  localparam int PAR    = WEIGHT_PARALLELISM_DIM_0;
  localparam int PREC   = WEIGHT_PRECISION_0;
  localparam int BPR    = WEIGHT_TENSOR_SIZE_DIM_0 / WEIGHT_PARALLELISM_DIM_0;
  localparam int RW     = WEIGHT_PRECISION_0 * WEIGHT_TENSOR_SIZE_DIM_0;
  localparam int AW     = $clog2(WEIGHT_TENSOR_SIZE_DIM_1) + 1;
  localparam int MEM_AW = (WEIGHT_TENSOR_SIZE_DIM_1 > 1) ? $clog2(WEIGHT_TENSOR_SIZE_DIM_1) : 1;
  localparam int BEAT_W = (BPR > 1) ? $clog2(BPR) : 1;
  localparam int OFF_W  = $clog2(RW);

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BPR - 1);
  localparam logic [BEAT_W-1:0] BEAT_ONE  = BEAT_W'(1);
  localparam logic [AW-1:0]     LAST_ROW  = AW'(WEIGHT_TENSOR_SIZE_DIM_1 - 1);
  localparam logic [AW-1:0]     ROW_ONE   = AW'(1);

  sink_state_t       state_r;
  logic [BEAT_W-1:0] beat_cnt_r;
  logic [AW-1:0]     row_cnt_r;
  logic [AW-1:0]     rows_loaded_r;
  logic              load_done_r;
  logic [RW-1:0]     shadow_r;
  logic [RW-1:0]     row_next_s;
  logic [OFF_W-1:0]  lane_off_s;
  logic              ready_s;
  logic              accept_s;
  logic              row_end_s;

  // Ready stays combinational on reload so a beat coinciding with reload is refused
  always_comb begin
    ready_s = 1'b0;
    if (rst_n && (state_r == LOAD) && !reload) begin
      ready_s = 1'b1;
    end else begin
      ready_s = 1'b0;
    end
  end

  assign accept_s  = data_in_valid & ready_s;
  assign row_end_s = accept_s & (beat_cnt_r == LAST_BEAT);

  // Merge the current beat into the shadow row; on the last beat this is the full RAM word
  always_comb begin
    row_next_s = shadow_r;
    lane_off_s = '0;
    for (int j = 0; j < PAR; j++) begin
      lane_off_s = OFF_W'(lane_offset(int'(beat_cnt_r), j, PAR, PREC));
      row_next_s[lane_off_s +: PREC] = data_in[j];
    end
  end

  // Load sequencing: beat/row counters, shadow packing and LOAD/DONE state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= LOAD;
      beat_cnt_r    <= '0;
      row_cnt_r     <= '0;
      rows_loaded_r <= '0;
      load_done_r   <= 1'b0;
      shadow_r      <= '0;
    end else if (reload) begin
      state_r       <= LOAD;
      beat_cnt_r    <= '0;
      row_cnt_r     <= '0;
      rows_loaded_r <= '0;
      load_done_r   <= 1'b0;
    end else begin
      case (state_r)
        LOAD: begin
          if (accept_s) begin
            shadow_r <= row_next_s;
            if (beat_cnt_r == LAST_BEAT) begin
              beat_cnt_r    <= '0;
              row_cnt_r     <= row_cnt_r + ROW_ONE;
              rows_loaded_r <= rows_loaded_r + ROW_ONE;
              if (row_cnt_r == LAST_ROW) begin
                state_r     <= DONE;
                load_done_r <= 1'b1;
              end
            end else begin
              beat_cnt_r <= beat_cnt_r + BEAT_ONE;
            end
          end
        end
        DONE: begin
          state_r <= DONE;
        end
        default: begin
          state_r <= LOAD;
        end
      endcase
    end
  end

  weight_row_ram #(
    .WIDTH  (RW),
    .DEPTH  (WEIGHT_TENSOR_SIZE_DIM_1),
    .AW     (AW),
    .MEM_AW (MEM_AW)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (row_end_s),
    .waddr (row_cnt_r[MEM_AW-1:0]),
    .wdata (row_next_s),
    .ce    (ce0),
    .raddr (address0),
    .q     (q0)
  );

  assign data_in_ready = ready_s;
  assign load_done     = load_done_r;
  assign rows_loaded   = rows_loaded_r;

endmodule

// File: tb/tb_weight_stream_sink_buffer.sv
// Directed bench for weight_stream_sink_buffer: lane value = base + row*32 + beat*4 + lane,
// so element k of row r is base + r*32 + k.
module tb_weight_stream_sink_buffer;
  import weight_stream_pkg::*;

  localparam int PAR  = WS_PAR;
  localparam int PREC = WS_PREC;
  localparam int BPR  = BEATS_PER_ROW;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [PREC-1:0]  data_in [PAR];
  logic             data_in_valid;
  logic             data_in_ready;
  logic             reload;
  logic             load_done;
  logic [2:0]       rows_loaded;
  logic [2:0]       address0;
  logic             ce0;
  weight_row_t      q0;

  int          n_cmp  = 0;
  int          n_fail = 0;
  int          cur_row;
  int          cur_beat;
  weight_row_t bench_row;
  weight_row_t model_mem [4];

  always #5 clk = ~clk;

  weight_stream_sink_buffer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .data_in       (data_in),
    .data_in_valid (data_in_valid),
    .data_in_ready (data_in_ready),
    .reload        (reload),
    .load_done     (load_done),
    .rows_loaded   (rows_loaded),
    .address0      (address0),
    .ce0           (ce0),
    .q0            (q0)
  );

  // Streams nbeats beats from the cursor; model rows are recorded as they complete
  task automatic load_beats(input int base, input int nbeats, input bit gaps, output int cycles);
    int done_n;
    bit acc;
    done_n = 0;
    cycles = 0;
    while (done_n < nbeats && cycles < 4000) begin
      data_in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      for (int j = 0; j < PAR; j++) data_in[j] = 16'(base + cur_row * 32 + cur_beat * PAR + j);
      #1;
      acc = data_in_valid && data_in_ready;
      @(posedge clk); #1;
      cycles++;
      if (acc) begin
        if (cur_beat == 0) bench_row = '0;
        for (int j = 0; j < PAR; j++)
          bench_row = bench_row | (weight_row_t'(data_in[j]) << ((cur_beat * PAR + j) * PREC));
        done_n++;
        cur_beat++;
        if (cur_beat == BPR) begin
          model_mem[cur_row] = bench_row;
          cur_beat = 0;
          cur_row++;
        end
      end
    end
    data_in_valid = 1'b0;
    if (done_n < nbeats) begin
      n_cmp++; n_fail++;
      $display("FAIL load_timeout: accepted=%0d required=%0d", done_n, nbeats);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; reload = 1'b0; ce0 = 1'b0; address0 = 3'd0; data_in_valid = 1'b1;
    for (int j = 0; j < PAR; j++) data_in[j] = 16'd0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (data_in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready: got=%b exp=0", data_in_ready); end
    n_cmp++; if (q0 !== '0) begin n_fail++; $display("FAIL rst_q0: got=%h exp=0", q0); end
    n_cmp++; if (load_done !== 1'b0) begin n_fail++; $display("FAIL rst_load_done: got=%b exp=0", load_done); end
    n_cmp++; if (rows_loaded !== 3'd0) begin n_fail++; $display("FAIL rst_rows_loaded: got=%0d exp=0", rows_loaded); end
    data_in_valid = 1'b0;
    @(negedge clk); rst_n = 1'b1; #1;
    n_cmp++; if (data_in_ready !== 1'b1) begin n_fail++; $display("FAIL post_rst_ready: got=%b exp=1", data_in_ready); end
    cur_row = 0; cur_beat = 0;
  endtask

  task automatic test_stream();
    int c1, c2;
    load_beats(0, 31, 1'b0, c1);
    n_cmp++; if (load_done !== 1'b0) begin n_fail++; $display("FAIL stream_done_early: got=%b exp=0", load_done); end
    n_cmp++; if (rows_loaded !== 3'd3) begin n_fail++; $display("FAIL stream_rows31: got=%0d exp=3", rows_loaded); end
    load_beats(0, 1, 1'b0, c2);
    n_cmp++; if (load_done !== 1'b1) begin n_fail++; $display("FAIL stream_done: got=%b exp=1", load_done); end
    n_cmp++; if (rows_loaded !== 3'd4) begin n_fail++; $display("FAIL stream_rows: got=%0d exp=4", rows_loaded); end
    n_cmp++; if (c1 + c2 !== 32) begin n_fail++; $display("FAIL stream_cycles: got=%0d exp=32", c1 + c2); end
  endtask

  // Pipelined reads of rows 0..3 then out-of-range address 5
  task automatic test_read(input string tag);
    logic [2:0]  addrs [5];
    weight_row_t exp_q [5];
    addrs = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd5};
    for (int i = 0; i < 4; i++) exp_q[i] = model_mem[i];
    exp_q[4] = '0;
    for (int i = 0; i < 6; i++) begin
      address0 = (i < 5) ? addrs[i] : 3'd0;
      ce0 = 1'b1;
      @(posedge clk); #1;
      if (i >= 1) begin
        n_cmp++;
        if (q0 !== exp_q[i-1]) begin
          n_fail++;
          $display("FAIL %s_addr%0d: got=%h exp=%h", tag, addrs[i-1], q0, exp_q[i-1]);
        end
      end
    end
    ce0 = 1'b0;
  endtask

  task automatic test_gaps();
    int c;
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    cur_row = 0; cur_beat = 0;
    load_beats(0, 32, 1'b1, c);
    n_cmp++; if (load_done !== 1'b1) begin n_fail++; $display("FAIL gaps_done: got=%b exp=1", load_done); end
    n_cmp++; if (rows_loaded !== 3'd4) begin n_fail++; $display("FAIL gaps_rows: got=%0d exp=4", rows_loaded); end
    test_read("gaps");
    data_in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      n_cmp++; if (data_in_ready !== 1'b0) begin n_fail++; $display("FAIL done_ready_c%0d: got=%b exp=0", i, data_in_ready); end
      @(posedge clk); #1;
    end
    data_in_valid = 1'b0;
    n_cmp++; if (rows_loaded !== 3'd4) begin n_fail++; $display("FAIL done_rows_hold: got=%0d exp=4", rows_loaded); end
  endtask

  task automatic test_reload();
    int c;
    reload = 1'b1;
    @(posedge clk); #1;
    reload = 1'b0;
    cur_row = 0; cur_beat = 0;
    load_beats(100, 2 * BPR + 3, 1'b0, c);
    n_cmp++; if (rows_loaded !== 3'd2) begin n_fail++; $display("FAIL reload_pre_rows: got=%0d exp=2", rows_loaded); end
    data_in_valid = 1'b1; reload = 1'b1;
    #1;
    n_cmp++; if (data_in_ready !== 1'b0) begin n_fail++; $display("FAIL reload_ready: got=%b exp=0", data_in_ready); end
    @(posedge clk); #1;
    reload = 1'b0; data_in_valid = 1'b0;
    n_cmp++; if (rows_loaded !== 3'd0) begin n_fail++; $display("FAIL reload_rows: got=%0d exp=0", rows_loaded); end
    n_cmp++; if (load_done !== 1'b0) begin n_fail++; $display("FAIL reload_done: got=%b exp=0", load_done); end
    cur_row = 0; cur_beat = 0;
  endtask

  task automatic test_collision();
    weight_row_t old_row1;
    int c;
    old_row1 = model_mem[1];
    load_beats(200, 2 * BPR - 1, 1'b0, c);
    address0 = 3'd1; ce0 = 1'b1;
    load_beats(200, 1, 1'b0, c);
    n_cmp++; if (rows_loaded !== 3'd2) begin n_fail++; $display("FAIL coll_rows: got=%0d exp=2", rows_loaded); end
    @(posedge clk); #1;
    n_cmp++; if (q0 !== old_row1) begin n_fail++; $display("FAIL coll_old: got=%h exp=%h", q0, old_row1); end
    @(posedge clk); #1;
    n_cmp++; if (q0 !== model_mem[1]) begin n_fail++; $display("FAIL coll_new: got=%h exp=%h", q0, model_mem[1]); end
    ce0 = 1'b0;
    load_beats(200, 2 * BPR, 1'b0, c);
    n_cmp++; if (load_done !== 1'b1) begin n_fail++; $display("FAIL reload2_done: got=%b exp=1", load_done); end
    test_read("reload");
  endtask

  task automatic test_freeze_async_reset();
    int c;
    address0 = 3'd2; ce0 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    ce0 = 1'b0; address0 = 3'd3;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_cmp++; if (q0 !== model_mem[2]) begin n_fail++; $display("FAIL freeze_c%0d: got=%h exp=%h", i, q0, model_mem[2]); end
    end
    reload = 1'b1;
    @(posedge clk); #1;
    reload = 1'b0;
    cur_row = 0; cur_beat = 0;
    load_beats(300, 2 * BPR + 4, 1'b0, c);
    n_cmp++; if (rows_loaded !== 3'd2) begin n_fail++; $display("FAIL mid_rows: got=%0d exp=2", rows_loaded); end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (q0 !== '0) begin n_fail++; $display("FAIL arst_q0: got=%h exp=0", q0); end
    n_cmp++; if (rows_loaded !== 3'd0) begin n_fail++; $display("FAIL arst_rows: got=%0d exp=0", rows_loaded); end
    n_cmp++; if (load_done !== 1'b0) begin n_fail++; $display("FAIL arst_done: got=%b exp=0", load_done); end
    n_cmp++; if (data_in_ready !== 1'b0) begin n_fail++; $display("FAIL arst_ready: got=%b exp=0", data_in_ready); end
    @(posedge clk); #2;
    rst_n = 1'b1;
    cur_row = 0; cur_beat = 0;
    load_beats(400, BPR, 1'b0, c);
    n_cmp++; if (rows_loaded !== 3'd1) begin n_fail++; $display("FAIL restart_rows: got=%0d exp=1", rows_loaded); end
    test_read("restart");
  endtask

  initial begin
    test_reset();
    test_stream();
    test_read("stream");
    test_gaps();
    test_reload();
    test_collision();
    test_freeze_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

endmodule
